// File: rtl/memory_access_hs_pkg.sv
// Shared opcodes, funct3 size codes, FSM encoding and small decode helpers
// for the handshaked MEM stage.
package memory_access_hs_pkg;

    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_S    = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        MA_IDLE = 2'd0,
        MA_REQ  = 2'd1,
        MA_RESP = 2'd2,
        MA_DONE = 2'd3
    } ma_state_e;

    function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
        if (is_load) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return off[0];
            F3_W:        return off != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] size_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << off;
            F3_H, F3_HU: return 4'b0011 << off;
            default:     return 4'b1111;
        endcase
    endfunction

    // Replicating the store value means the bus picks the right lane via be alone.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            F3_B:    return {4{v[7:0]}};
            F3_H:    return {2{v[15:0]}};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_hs_load_align.sv
// Selects the addressed byte/half of a word-aligned read and extends it.
module memory_access_hs_load_align
    import memory_access_hs_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {24'h0, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {16'h0, shifted[15:0]};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access_hs.sv
// MEM stage: decodes loads/stores and runs one req/gnt/rvalid bus access at a
// time, stalling the pipeline until it completes, is rejected, or times out.
module memory_access_hs
    import memory_access_hs_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              M_valid_i,
    input  logic [6:0]        M_opcode_i,
    input  logic [9:0]        M_funct_i,
    input  logic [31:0]       M_valE_i,
    input  logic [31:0]       M_val2_i,
    output logic [31:0]       m_valM_o,
    output logic              m_valid_o,
    output logic              m_stall_o,
    output logic              m_misalign_o,
    output logic              m_buserr_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [31:0]       dmem_rdata_i
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    ma_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       result_q, result_d;
    logic              buserr_q, buserr_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              is_load, is_store, mem_op, bad_op, expired;
    logic [2:0]        f3_in;
    logic [31:0]       load_val;
    logic              unused_funct7;

    assign f3_in         = M_funct_i[2:0];
    assign unused_funct7 = ^M_funct_i[9:3];
    assign is_load       = (M_opcode_i == OP_LOAD);
    assign is_store      = (M_opcode_i == OP_S);
    assign mem_op        = M_valid_i && (is_load || is_store);
    assign bad_op        = !f3_legal(is_load, f3_in) || misaligned(f3_in, M_valE_i[1:0]);
    assign expired       = (cnt_q >= CNT_LAST);

    memory_access_hs_load_align u_load_align (
        .rdata_i  (dmem_rdata_i),
        .off_i    (off_q),
        .funct3_i (f3_q),
        .data_o   (load_val)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        f3_d     = f3_q;
        off_d    = off_q;
        result_d = result_q;
        buserr_d = buserr_q;
        cnt_d    = cnt_q;
        case (state_q)
            MA_IDLE: begin
                if (mem_op && !bad_op) begin
                    state_d  = MA_REQ;
                    addr_d   = {M_valE_i[ADDR_W-1:2], 2'b00};
                    we_d     = is_store;
                    be_d     = size_be(f3_in, M_valE_i[1:0]);
                    wdata_d  = is_store ? store_wdata(f3_in, M_val2_i) : 32'h0;
                    f3_d     = f3_in;
                    off_d    = M_valE_i[1:0];
                    result_d = 32'h0;
                    buserr_d = 1'b0;
                    cnt_d    = 8'h0;
                end
            end
            MA_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (dmem_gnt_i) begin
                    state_d = we_q ? MA_DONE : MA_RESP;
                end else if (expired) begin
                    state_d  = MA_DONE;
                    buserr_d = 1'b1;
                end
            end
            MA_RESP: begin
                // rvalid is only honoured here, never in the grant cycle.
                cnt_d = cnt_q + 8'd1;
                if (dmem_rvalid_i) begin
                    state_d  = MA_DONE;
                    result_d = load_val;
                end else if (expired) begin
                    state_d  = MA_DONE;
                    buserr_d = 1'b1;
                end
            end
            MA_DONE: state_d = MA_IDLE;
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= MA_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            f3_q     <= 3'h0;
            off_q    <= 2'h0;
            result_q <= 32'h0;
            buserr_q <= 1'b0;
            cnt_q    <= 8'h0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            f3_q     <= f3_d;
            off_q    <= off_d;
            result_q <= result_d;
            buserr_q <= buserr_d;
            cnt_q    <= cnt_d;
        end
    end

    // IDLE outputs are a combinational view of the M inputs; all others come from flops.
    always_comb begin
        m_valM_o     = 32'h0;
        m_valid_o    = 1'b0;
        m_stall_o    = 1'b0;
        m_misalign_o = 1'b0;
        m_buserr_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = 4'h0;
        dmem_wdata_o = 32'h0;
        if (!rst_i) begin
            case (state_q)
                MA_IDLE: begin
                    m_valid_o    = M_valid_i && (!mem_op || bad_op);
                    m_misalign_o = mem_op && bad_op;
                    m_stall_o    = mem_op && !bad_op;
                end
                MA_REQ: begin
                    m_stall_o    = 1'b1;
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = we_q;
                    dmem_addr_o  = addr_q;
                    dmem_be_o    = be_q;
                    dmem_wdata_o = wdata_q;
                end
                MA_RESP: m_stall_o = 1'b1;
                MA_DONE: begin
                    m_valid_o  = 1'b1;
                    m_valM_o   = result_q;
                    m_buserr_o = buserr_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_hs.sv
// Randomised scoreboard bench for memory_access_hs with a behavioural bus responder.
module tb_memory_access_hs;
    import memory_access_hs_pkg::*;

    localparam int TIMEOUT = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        M_valid_i = 1'b0;
    logic [6:0]  M_opcode_i = 7'h0;
    logic [9:0]  M_funct_i = 10'h0;
    logic [31:0] M_valE_i = 32'h0;
    logic [31:0] M_val2_i = 32'h0;
    logic [31:0] m_valM_o;
    logic        m_valid_o, m_stall_o, m_misalign_o, m_buserr_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;

    memory_access_hs #(.ADDR_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk_i, .rst_i, .M_valid_i, .M_opcode_i, .M_funct_i, .M_valE_i, .M_val2_i,
        .m_valM_o, .m_valid_o, .m_stall_o, .m_misalign_o, .m_buserr_o,
        .dmem_req_o, .dmem_we_o, .dmem_addr_o, .dmem_be_o, .dmem_wdata_o,
        .dmem_gnt_i, .dmem_rvalid_i, .dmem_rdata_i
    );

    // ---------------- clock / watchdog ----------------
    initial forever #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [34:0] exp_q[$];   // {valM, misalign, buserr, stall} at m_valid_o
    logic [68:0] bus_q[$];   // {we, addr, be, wdata} at request start
    int          len_q[$];   // request length in cycles

    int          cfg_g = 0, cfg_r = 0;
    bit          cfg_never = 0, cfg_spur = 0, cfg_norv = 0;
    logic [31:0] cfg_rdata = 32'h0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit ref_legal(input bit ld, input logic [2:0] f3);
        return ld ? (f3 != 3 && f3 < 6) : (f3 < 3);
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int unsigned b, h;
        b = 32'((rd >> (8 * (a % 4))) % 256);
        h = 32'((rd >> (8 * (a % 4))) % 65536);
        case (f3)
            3'd0:    return (b >= 128) ? 32'(b - 256) : 32'(b);
            3'd4:    return 32'(b);
            3'd1:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
            3'd5:    return 32'(h);
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned off;
        off = a % 4;
        case (f3)
            3'd0:    return 4'(1 << off);
            3'd1:    return 4'(3 << off);
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] v);
        case (f3)
            3'd0:    return 32'((v % 256) * 32'h01010101);
            3'd1:    return 32'((v % 65536) * 32'h00010001);
            default: return v;
        endcase
    endfunction

    // ---------------- bus responder ----------------
    initial begin
        bit ld;
        dmem_gnt_i = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'h0;
        forever begin
            @(posedge clk_i); #1;
            if (dmem_req_o) begin
                if (cfg_never) begin
                    for (int i = 0; i < 300 && dmem_req_o; i++) begin
                        @(posedge clk_i); #1;
                    end
                end else begin
                    ld = !dmem_we_o;
                    repeat (cfg_g) begin @(posedge clk_i); #1; end
                    dmem_gnt_i = 1'b1;
                    if (cfg_spur && ld) begin
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i  = ~cfg_rdata;
                    end
                    @(posedge clk_i); #1;
                    dmem_gnt_i = 1'b0;
                    dmem_rvalid_i = 1'b0;
                    dmem_rdata_i = 32'h0;
                    if (ld && !cfg_norv) begin
                        repeat (cfg_r) begin @(posedge clk_i); #1; end
                        dmem_rvalid_i = 1'b1;
                        dmem_rdata_i  = cfg_rdata;
                        @(posedge clk_i); #1;
                        dmem_rvalid_i = 1'b0;
                        dmem_rdata_i  = 32'h0;
                    end
                end
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        logic [34:0] e;
        forever begin
            @(negedge clk_i);
            if (m_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_valid: got valid with valM 0x%0h, expected no valid", m_valM_o);
                end else begin
                    e = exp_q.pop_front();
                    check("result", {m_valM_o, m_misalign_o, m_buserr_o, m_stall_o}, e);
                end
            end
        end
    end

    initial begin
        logic [68:0] cur;
        logic        req_prev;
        bit          have;
        int          len, elen;
        req_prev = 1'b0;
        have = 0;
        len = 0;
        forever begin
            @(negedge clk_i);
            if (dmem_req_o && !req_prev) begin
                if (bus_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    have = 0;
                    $display("FAIL unexpected_req: got req addr 0x%0h, expected no request", dmem_addr_o);
                end else begin
                    cur = bus_q.pop_front();
                    have = 1;
                end
            end
            if (dmem_req_o && have) begin
                if (cur[68]) check("bus_store", {dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, cur);
                else         check("bus_load", {dmem_we_o, dmem_addr_o}, cur[68:36]);
            end
            if (dmem_req_o) len++;
            if (!dmem_req_o && req_prev) begin
                elen = (len_q.size() != 0) ? len_q.pop_front() : -1;
                check("req_len", len, elen);
                len = 0;
                have = 0;
            end
            req_prev = dmem_req_o;
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic vld, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] val2,
                          input logic [31:0] rdata, input int g, input int r,
                          input bit never, input bit spur);
        bit          ld, st, mem, bad;
        int          exp_stall, stalls;
        logic [31:0] res;
        ld  = (op == OP_LOAD);
        st  = (op == OP_S);
        mem = vld && (ld || st);
        bad = mem && (!ref_legal(ld, f3) || ref_misaligned(f3, addr));
        cfg_g = g; cfg_r = r; cfg_never = never; cfg_spur = spur; cfg_norv = 0;
        cfg_rdata = rdata;
        exp_stall = 0;
        if (vld && !mem) begin
            exp_q.push_back({32'h0, 3'b000});
        end else if (bad) begin
            exp_q.push_back({32'h0, 3'b100});
        end else if (mem) begin
            res = (ld && !never) ? ref_load(f3, addr, rdata) : 32'h0;
            exp_q.push_back({res, 1'b0, 1'(never), 1'b0});
            bus_q.push_back({1'(st), 32'(addr - addr % 4), ref_be(f3, addr),
                             st ? ref_wdata(f3, val2) : 32'h0});
            len_q.push_back(never ? TIMEOUT : g + 1);
            exp_stall = never ? 1 + TIMEOUT : (st ? 2 + g : 3 + g + r);
        end
        M_valid_i  = vld;
        M_opcode_i = op;
        M_funct_i  = {7'($urandom), f3};
        M_valE_i   = addr;
        M_val2_i   = val2;
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (m_stall_o) stalls++;
            else break;
        end
        check("stall_cycles", stalls, exp_stall);
        @(posedge clk_i); #1;
        M_valid_i = 1'b0;
    endtask

    localparam logic [6:0] OP_ALU = 7'b0110011;

    initial begin
        logic [6:0] op;
        int sel;
        // reset with a live non-mem op on the inputs: everything must stay quiet
        rst_i = 1'b1;
        M_valid_i = 1'b1;
        M_opcode_i = OP_ALU;
        repeat (3) begin
            @(negedge clk_i);
            check("reset_ctrl", {m_valid_o, m_stall_o, m_misalign_o, m_buserr_o, dmem_req_o, dmem_we_o}, 6'h0);
            check("reset_data", {m_valM_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, 100'h0);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        M_valid_i = 1'b0;

        // directed cases
        run_op(1, OP_LOAD, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 2, 0, 0, 0);
        run_op(1, OP_LOAD, F3_B,  32'h103, 32'h0, 32'h80FFFF7F, 0, 1, 0, 0);
        run_op(1, OP_LOAD, F3_BU, 32'h103, 32'h0, 32'h80FFFF7F, 1, 0, 0, 1);
        run_op(1, OP_LOAD, F3_H,  32'h102, 32'h0, 32'h80FFFF7F, 0, 0, 0, 1);
        run_op(1, OP_LOAD, F3_HU, 32'h102, 32'h0, 32'h80FFFF7F, 3, 2, 0, 0);
        run_op(1, OP_S,    F3_H,  32'h202, 32'h1234ABCD, 32'h0, 0, 0, 0, 0);
        run_op(1, OP_LOAD, F3_W,  32'h101, 32'h0, 32'h0, 0, 0, 0, 0);
        run_op(1, OP_S,    3'd3,  32'h200, 32'h0, 32'h0, 0, 0, 0, 0);
        run_op(1, OP_LOAD, 3'd6,  32'h200, 32'h0, 32'h0, 0, 0, 0, 0);
        run_op(1, OP_LOAD, F3_W,  32'h400, 32'h0, 32'h11111111, 0, 0, 1, 0);
        run_op(1, OP_S,    F3_B,  32'h401, 32'hA5, 32'h0, 0, 0, 1, 0);

        // a late grant while idle must not wake the FSM
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        check("late_gnt_idle", {m_valid_o, m_stall_o, dmem_req_o}, 3'b000);
        @(posedge clk_i); #1;
        dmem_gnt_i = 1'b0;

        // reset pulsed while waiting for read data
        cfg_g = 0; cfg_never = 0; cfg_spur = 0; cfg_norv = 1;
        bus_q.push_back({1'b0, 32'h300, 4'hF, 32'h0});
        len_q.push_back(1);
        M_valid_i = 1'b1; M_opcode_i = OP_LOAD; M_funct_i = {7'h0, F3_W};
        M_valE_i = 32'h300; M_val2_i = 32'h0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        M_valid_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("midreset_ctrl", {m_valid_o, m_stall_o, m_misalign_o, m_buserr_o, dmem_req_o}, 5'h0);
        check("midreset_data", m_valM_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i = 32'hCAFEF00D;
        @(negedge clk_i);
        check("late_rvalid_idle", {m_valid_o, m_stall_o, dmem_req_o}, 3'b000);
        @(posedge clk_i); #1;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i = 32'h0;
        cfg_norv = 0;
        repeat (2) @(posedge clk_i);
        #1;

        // randomised traffic
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            op = (sel < 4) ? OP_LOAD : (sel < 8) ? OP_S : OP_ALU;
            run_op($urandom_range(0, 9) != 0, op, 3'($urandom_range(0, 7)),
                   $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
        end

        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        check("exp_q_drained", exp_q.size(), 0);
        check("bus_q_drained", bus_q.size(), 0);
        check("len_q_drained", len_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
